// File: rtl/collision_detector.sv
// rtl/collision_detector.sv - scans the obstacle slot table against the shrunk t-rex box and drives the sticky crash flag
// Optional macro COLLISION_HIT_INDEX_EN adds hit_idx, the slot that first set crash.
module collision_detector #(
  parameter int MAX_OBSTACLES = 4,
  parameter int MARGIN        = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             update,
  input  logic signed [11:0]               trex_x,
  input  logic signed [11:0]               trex_y,
  input  logic [9:0]                       trex_w,
  input  logic [9:0]                       trex_h,
  output logic [$clog2(MAX_OBSTACLES)-1:0] obs_idx,
  input  logic                             obs_valid,
  input  logic signed [11:0]               obs_x,
  input  logic signed [11:0]               obs_y,
  input  logic [9:0]                       obs_w,
  input  logic [9:0]                       obs_h,
  output logic                             busy,
  output logic                             done,
`ifdef COLLISION_HIT_INDEX_EN
  output logic [$clog2(MAX_OBSTACLES)-1:0] hit_idx,
`endif
  output logic                             crash
);
  localparam int IW = $clog2(MAX_OBSTACLES);
  localparam logic signed [12:0] M1 = 13'(MARGIN);
  localparam logic signed [12:0] M2 = 13'(2 * MARGIN);
  localparam logic [IW-1:0] LAST = IW'(MAX_OBSTACLES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, CHECK, DONE} state_t;
  state_t state, state_nx;

  logic signed [12:0] ta_x, ta_y, ta_w, ta_h;
  logic               ta_empty;
  logic signed [12:0] nt_x, nt_y, nt_w, nt_h;
  logic signed [12:0] ob_x, ob_y, ob_w, ob_h;
  logic               nt_empty, ob_empty, hit;

  // 13-bit signed keeps edge + size from wrapping for any 12-bit position and 10-bit size
  always_comb begin
    nt_x     = {trex_x[11], trex_x} + M1;
    nt_y     = {trex_y[11], trex_y} + M1;
    nt_w     = $signed({3'b000, trex_w}) - M2;
    nt_h     = $signed({3'b000, trex_h}) - M2;
    nt_empty = ($signed({3'b000, trex_w}) <= M2) || ($signed({3'b000, trex_h}) <= M2);
    ob_x     = {obs_x[11], obs_x} + M1;
    ob_y     = {obs_y[11], obs_y} + M1;
    ob_w     = $signed({3'b000, obs_w}) - M2;
    ob_h     = $signed({3'b000, obs_h}) - M2;
    ob_empty = ($signed({3'b000, obs_w}) <= M2) || ($signed({3'b000, obs_h}) <= M2);
    hit      = obs_valid && !ta_empty && !ob_empty &&
               (ta_x < ob_x + ob_w) && (ob_x < ta_x + ta_w) &&
               (ta_y < ob_y + ob_h) && (ob_y < ta_y + ta_h);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (update) state_nx = FETCH;
      FETCH: begin
        busy     = 1'b1;
        state_nx = CHECK;
      end
      CHECK: begin
        busy     = 1'b1;
        state_nx = (hit || obs_idx == LAST) ? DONE : FETCH;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      obs_idx  <= '0;
      crash    <= 1'b0;
      ta_x     <= '0;
      ta_y     <= '0;
      ta_w     <= '0;
      ta_h     <= '0;
      ta_empty <= 1'b1;
`ifdef COLLISION_HIT_INDEX_EN
      hit_idx  <= '0;
`endif
    end else begin
      if (state == IDLE && update) begin
        obs_idx  <= '0;
        ta_x     <= nt_x;
        ta_y     <= nt_y;
        ta_w     <= nt_w;
        ta_h     <= nt_h;
        ta_empty <= nt_empty;
      end
      if (state == CHECK) begin
        if (hit) begin
          crash <= 1'b1;
`ifdef COLLISION_HIT_INDEX_EN
          if (!crash) hit_idx <= obs_idx;
`endif
        end else if (obs_idx != LAST) begin
          obs_idx <= obs_idx + IW'(1);
        end
      end
    end
  end

endmodule
